// File: rtl/clk_freq_mon.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | clk_freq_mon                                                               |
// | Counts rising edges of an asynchronous clock over a fixed gate window and  |
// | flags windows whose count falls outside EXP_COUNT +/- TOL.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module clk_freq_mon #(
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int EXP_COUNT     = 4000,
  parameter int TOL           = 4,
  parameter int CNT_W         = 16,
  parameter int ERR_W         = 8
) (
  input  logic             clk_100M,
  input  logic             reset_n,
  input  logic             locked,
  input  logic             clk_in,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GATE_W   = $clog2(GATE_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int DIFF_W   = CNT_W + 1;

  localparam logic [GATE_W-1:0]   C_GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] C_SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [DIFF_W-1:0]   C_EXP         = DIFF_W'(EXP_COUNT);
  localparam logic [DIFF_W-1:0]   C_TOL         = DIFF_W'(TOL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_lock_s1;
  logic                r_lock_s;
  logic                r_clk_s1;
  logic                r_clk_s2;
  logic                r_clk_s3;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [GATE_W-1:0]   r_gate_cnt;
  logic [CNT_W-1:0]    r_edge_cnt;

  logic                w_edge;
  logic [CNT_W-1:0]    w_edge_next;
  logic [DIFF_W-1:0]   w_cnt_ext;
  logic [DIFF_W-1:0]   w_diff;
  logic                w_in_tol;

  // Two-flop synchronizers; clk_in gets a third flop for edge detection.
  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_s1 <= 1'b0;
      r_lock_s  <= 1'b0;
      r_clk_s1  <= 1'b0;
      r_clk_s2  <= 1'b0;
      r_clk_s3  <= 1'b0;
    end else begin
      r_lock_s1 <= locked;
      r_lock_s  <= r_lock_s1;
      r_clk_s1  <= clk_in;
      r_clk_s2  <= r_clk_s1;
      r_clk_s3  <= r_clk_s2;
    end
  end

  assign w_edge = r_clk_s2 & ~r_clk_s3;

  // Saturating edge count including this cycle's pulse.
  always_comb begin
    w_edge_next = r_edge_cnt;
    if (w_edge && (r_edge_cnt != {CNT_W{1'b1}})) begin
      w_edge_next = r_edge_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_cnt_ext = {1'b0, w_edge_next};
    w_diff    = (w_cnt_ext >= C_EXP) ? (w_cnt_ext - C_EXP) : (C_EXP - w_cnt_ext);
    w_in_tol  = (w_diff <= C_TOL);
  end

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      meas_count   <= '0;
      meas_valid   <= 1'b0;
      freq_ok      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      meas_valid <= 1'b0;
      if (!r_lock_s) begin
        // Lock lost: abandon the current window without publishing it.
        r_state      <= S_IDLE;
        r_settle_cnt <= '0;
        r_gate_cnt   <= '0;
        r_edge_cnt   <= '0;
        freq_ok      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= '0;
          end
          S_SETTLE: begin
            if (r_settle_cnt == C_SETTLE_LAST) begin
              r_state      <= S_GATE;
              r_settle_cnt <= '0;
              r_gate_cnt   <= '0;
              r_edge_cnt   <= '0;
            end else begin
              r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
            end
          end
          S_GATE: begin
            if (r_gate_cnt == C_GATE_LAST) begin
              r_gate_cnt <= '0;
              r_edge_cnt <= '0;
              meas_count <= w_edge_next;
              meas_valid <= 1'b1;
              freq_ok    <= w_in_tol;
              if (!w_in_tol && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_W'(1);
              end
            end else begin
              r_gate_cnt <= r_gate_cnt + GATE_W'(1);
              r_edge_cnt <= w_edge_next;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_freq_mon.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_clk_freq_mon                                                            |
// | Directed vectors and corner sequences for clk_freq_mon.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_clk_freq_mon;

  localparam int GATE   = 1000;
  localparam int SETTLE = 16;
  localparam int EXPC   = 40;
  localparam int TOLV   = 1;
  localparam int LAT    = 2 + SETTLE + GATE;

  logic        clk_100M = 1'b0;
  logic        reset_n  = 1'b0;
  logic        locked   = 1'b0;
  logic        clk_in   = 1'b0;
  logic        fast_in  = 1'b0;
  int          half     = 125;

  logic [15:0] meas_count;
  logic        meas_valid;
  logic        freq_ok;
  logic [7:0]  err_cnt;

  logic [15:0] sat_count;
  logic        sat_valid;
  logic        sat_ok;
  logic [7:0]  sat_err;

  logic [3:0]  cnt_count;
  logic        cnt_valid;
  logic        cnt_ok;
  logic [7:0]  cnt_err;

  int total = 0;
  int bad   = 0;

  clk_freq_mon #(
    .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .EXP_COUNT(EXPC), .TOL(TOLV),
    .CNT_W(16), .ERR_W(8)
  ) u_dut (
    .clk_100M(clk_100M), .reset_n(reset_n), .locked(locked), .clk_in(clk_in),
    .meas_count(meas_count), .meas_valid(meas_valid), .freq_ok(freq_ok), .err_cnt(err_cnt)
  );

  // Short windows with a dead clock to reach error-counter saturation quickly.
  clk_freq_mon #(
    .GATE_CYCLES(8), .SETTLE_CYCLES(1), .EXP_COUNT(EXPC), .TOL(TOLV),
    .CNT_W(16), .ERR_W(8)
  ) u_sat (
    .clk_100M(clk_100M), .reset_n(reset_n), .locked(locked), .clk_in(1'b0),
    .meas_count(sat_count), .meas_valid(sat_valid), .freq_ok(sat_ok), .err_cnt(sat_err)
  );

  // Narrow edge counter fed with 25 edges per window: must stick at 15.
  clk_freq_mon #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(1), .EXP_COUNT(10), .TOL(1),
    .CNT_W(4), .ERR_W(8)
  ) u_cnt (
    .clk_100M(clk_100M), .reset_n(reset_n), .locked(locked), .clk_in(fast_in),
    .meas_count(cnt_count), .meas_valid(cnt_valid), .freq_ok(cnt_ok), .err_cnt(cnt_err)
  );

  always #5 clk_100M = ~clk_100M;

  // Monitored clock; all toggles sit 3 ns off the 5 ns grid so they never hit a clock edge.
  initial begin
    #3;
    forever begin
      if (half == 0) begin
        clk_in = 1'b0;
        #10;
      end else begin
        #(half) clk_in = ~clk_in;
      end
    end
  end

  initial begin
    #2;
    forever #20 fast_in = ~fast_in;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Returns the number of rising edges until meas_valid is seen (bounded).
  task automatic wait_valid(input string name, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk_100M);
      n++;
      @(negedge clk_100M);
    end while (!meas_valid && n < limit);
    chk({name, "_valid"}, int'(meas_valid), 1);
  endtask

  typedef struct {
    int half_ns;
    int lo;
    int hi;
    int ok;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    int err_before;
    int saved;
    int seen;
    int w;

    vecs[0] = '{half_ns: 125, lo: 39, hi: 41, ok: 1};  // 4 MHz
    vecs[1] = '{half_ns: 100, lo: 49, hi: 51, ok: 0};  // 5 MHz
    vecs[2] = '{half_ns: 165, lo: 29, hi: 31, ok: 0};  // ~3.03 MHz
    vecs[3] = '{half_ns: 125, lo: 39, hi: 41, ok: 1};

    // Reset held with lock and a running clock.
    reset_n = 1'b0;
    locked  = 1'b1;
    repeat (10) begin
      @(negedge clk_100M);
      chk("reset_hold", int'({meas_count, meas_valid, freq_ok, err_cnt}), 0);
    end
    locked = 1'b0;
    @(negedge clk_100M);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_100M);

    // Nominal: latency counted in edges after the one that first samples locked.
    locked = 1'b1;
    @(posedge clk_100M);
    wait_valid("first", LAT + 50, n);
    chk("first_latency", n, LAT);
    chk_rng("nominal_count", int'(meas_count), 39, 41);
    chk("nominal_ok", int'(freq_ok), 1);
    chk("nominal_err", int'(err_cnt), 0);
    wait_valid("second", GATE + 50, n);
    chk("period", n, GATE);
    chk_rng("nominal_count2", int'(meas_count), 39, 41);

    // Table of frequencies: first window after a change is mixed and skipped.
    for (int i = 0; i < 4; i++) begin
      half = vecs[i].half_ns;
      wait_valid("vec_skip", GATE + 50, n);
      err_before = int'(err_cnt);
      wait_valid("vec", GATE + 50, n);
      chk("vec_period", n, GATE);
      chk_rng("vec_count", int'(meas_count), vecs[i].lo, vecs[i].hi);
      chk("vec_ok", int'(freq_ok), vecs[i].ok);
      chk("vec_err", int'(err_cnt), err_before + (vecs[i].ok != 0 ? 0 : 1));
    end

    // Off frequency from a clean reset: error count 1, 2, 3.
    @(negedge clk_100M);
    reset_n = 1'b0;
    half    = 100;
    repeat (30) @(negedge clk_100M);
    reset_n = 1'b1;
    @(posedge clk_100M);
    for (int k = 1; k <= 3; k++) begin
      wait_valid("off", LAT + 50, n);
      chk_rng("off_count", int'(meas_count), 49, 51);
      chk("off_ok", int'(freq_ok), 0);
      chk("off_err", int'(err_cnt), k);
    end

    // Lock loss mid-window.
    half = 125;
    wait_valid("ll_skip", GATE + 50, n);
    wait_valid("ll_pre", GATE + 50, n);
    chk("ll_pre_ok", int'(freq_ok), 1);
    saved = int'(meas_count);
    repeat (500) @(posedge clk_100M);
    @(negedge clk_100M);
    locked = 1'b0;
    @(posedge clk_100M); @(negedge clk_100M);
    chk("ll_ok_e0", int'(freq_ok), 1);
    @(posedge clk_100M); @(negedge clk_100M);
    chk("ll_ok_e1", int'(freq_ok), 1);
    @(posedge clk_100M); @(negedge clk_100M);
    chk("ll_ok_e2", int'(freq_ok), 0);
    seen = 0;
    repeat (1100) begin
      @(negedge clk_100M);
      if (meas_valid) seen = 1;
    end
    chk("ll_no_valid", seen, 0);
    chk("ll_count_held", int'(meas_count), saved);
    locked = 1'b1;
    @(posedge clk_100M);
    wait_valid("relock", LAT + 50, n);
    chk("relock_latency", n, LAT);
    chk("relock_ok", int'(freq_ok), 1);

    // Asynchronous reset mid-window, away from any clock edge.
    repeat (300) @(posedge clk_100M);
    @(negedge clk_100M);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_count", int'(meas_count), 0);
    chk("ar_valid", int'(meas_valid), 0);
    chk("ar_ok", int'(freq_ok), 0);
    chk("ar_err", int'(err_cnt), 0);
    @(negedge clk_100M);
    reset_n = 1'b1;
    @(posedge clk_100M);
    wait_valid("ar_restart", LAT + 50, n);
    chk("ar_latency", n, LAT);

    // Error counter saturation on the short-window instance.
    @(negedge clk_100M);
    reset_n = 1'b0;
    @(negedge clk_100M);
    reset_n = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      w = 0;
      do begin
        @(posedge clk_100M);
        w++;
        @(negedge clk_100M);
      end while (!sat_valid && w < 40);
      chk("sat_valid", int'(sat_valid), 1);
      chk("sat_err", int'(sat_err), (k < 255) ? k : 255);
      if (k == 1 || k == 260) begin
        chk("sat_count", int'(sat_count), 0);
        chk("sat_ok", int'(sat_ok), 0);
      end
    end

    // Edge-counter saturation on the narrow instance.
    w = 0;
    do begin
      @(posedge clk_100M);
      w++;
      @(negedge clk_100M);
    end while (!cnt_valid && w < 250);
    chk("cnt_valid", int'(cnt_valid), 1);
    chk("cnt_sat_count", int'(cnt_count), 15);
    chk("cnt_sat_ok", int'(cnt_ok), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
